// File: rtl/dcache_ram_pkg.sv
// Shared constants for the dcache dual-port RAM: read-during-write policy
// and the clear-engine state encoding.
package dcache_ram_pkg;

    typedef enum logic {
        RDW_NEW = 1'b0,
        RDW_OLD = 1'b1
    } rdw_mode_e;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } clr_state_e;

    localparam int BYTE_W = 8;

endpackage

// File: rtl/ram_clear_ctrl.sv
// Post-reset zero-fill engine. While clearing it owns port A's write path,
// sweeping one address per cycle; afterwards port A passes straight through.
module ram_clear_ctrl
    import dcache_ram_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 5,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en_a,
    input  logic                      we_a,
    input  logic [DATA_WIDTH/8-1:0]   be_a,
    input  logic [ADDR_WIDTH-1:0]     addr_a,
    input  logic [DATA_WIDTH-1:0]     data_a,
    output logic                      busy,
    output logic                      wa_en,
    output logic                      wa_we,
    output logic [DATA_WIDTH/8-1:0]   wa_be,
    output logic [ADDR_WIDTH-1:0]     wa_addr,
    output logic [DATA_WIDTH-1:0]     wa_data
);

    localparam clr_state_e RST_STATE = CLEAR_ON_RESET ? CLEAR : READY;

    clr_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RST_STATE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        busy    = 1'b0;
        wa_en   = en_a;
        wa_we   = we_a;
        wa_be   = be_a;
        wa_addr = addr_a;
        wa_data = data_a;
        case (state_q)
            CLEAR: begin
                busy    = 1'b1;
                wa_en   = 1'b1;
                wa_we   = 1'b1;
                wa_be   = '1;
                wa_addr = addr_q;
                wa_data = '0;
                addr_d  = addr_q + ADDR_WIDTH'(1);
                if (addr_q == '1) state_d = READY;
            end
            READY: ;
            default: state_d = RST_STATE;
        endcase
    end

endmodule

// File: rtl/dcache_dual_port_ram.sv
// Dual-port byte-writable RAM with optional output register, same-port
// read-during-write policy, dual-write collision flag and reset-time clear.
module dcache_dual_port_ram
    import dcache_ram_pkg::*;
#(
    parameter int        DATA_WIDTH     = 32,
    parameter int        ADDR_WIDTH     = 5,
    parameter bit        OUT_REG        = 1'b0,
    parameter rdw_mode_e RDW_MODE       = RDW_NEW,
    parameter bit        CLEAR_ON_RESET = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en_a,
    input  logic                      en_b,
    input  logic                      we_a,
    input  logic                      we_b,
    input  logic [DATA_WIDTH/8-1:0]   be_a,
    input  logic [DATA_WIDTH/8-1:0]   be_b,
    input  logic [ADDR_WIDTH-1:0]     addr_a,
    input  logic [ADDR_WIDTH-1:0]     addr_b,
    input  logic [DATA_WIDTH-1:0]     data_a,
    input  logic [DATA_WIDTH-1:0]     data_b,
    output logic [DATA_WIDTH-1:0]     q_a,
    output logic [DATA_WIDTH-1:0]     q_b,
    output logic                      valid_a,
    output logic                      valid_b,
    output logic                      busy,
    output logic                      collision
);

    localparam int NB     = DATA_WIDTH / BYTE_W;
    localparam int DEPTH  = 1 << ADDR_WIDTH;
    localparam int STAGES = OUT_REG ? 2 : 1;

    logic                    wa_en, wa_we;
    logic [NB-1:0]           wa_be;
    logic [ADDR_WIDTH-1:0]   wa_addr;
    logic [DATA_WIDTH-1:0]   wa_data;

    ram_clear_ctrl #(
        .DATA_WIDTH     (DATA_WIDTH),
        .ADDR_WIDTH     (ADDR_WIDTH),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear (
        .clk     (clk),
        .rst     (rst),
        .en_a    (en_a),
        .we_a    (we_a),
        .be_a    (be_a),
        .addr_a  (addr_a),
        .data_a  (data_a),
        .busy    (busy),
        .wa_en   (wa_en),
        .wa_we   (wa_we),
        .wa_be   (wa_be),
        .wa_addr (wa_addr),
        .wa_data (wa_data)
    );

    // Index 0 is port A (possibly driven by the clear engine), 1 is port B.
    logic [1:0]                          usr_acc;
    logic [1:0][NB-1:0]                  wr_lane;
    logic [1:0][ADDR_WIDTH-1:0]          addr;
    logic [1:0][NB-1:0][BYTE_W-1:0]      wdata;
    logic [1:0][NB-1:0][BYTE_W-1:0]      rd_d;

    logic [NB-1:0][BYTE_W-1:0]           mem [DEPTH];

    logic [1:0][STAGES-1:0]                  vld_pipe_q, vld_pipe_d;
    logic [1:0][STAGES-1:0][DATA_WIDTH-1:0]  dat_pipe_q, dat_pipe_d;
    logic                                    collision_q, collision_d;

    always_comb begin
        usr_acc[0] = en_a & ~busy;
        usr_acc[1] = en_b & ~busy;
        wr_lane[0] = (wa_en & wa_we) ? wa_be : '0;
        wr_lane[1] = (usr_acc[1] & we_b) ? be_b : '0;
        addr[0]    = wa_addr;
        addr[1]    = addr_b;
        wdata[0]   = wa_data;
        wdata[1]   = data_b;
    end

    assign collision_d = (addr[0] == addr[1]) && ((wr_lane[0] & wr_lane[1]) != '0);

    // Array reads see pre-edge contents, so cross-port reads get the old word.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_d[p] = mem[addr[p]];
            if (RDW_MODE == RDW_NEW) begin
                for (int i = 0; i < NB; i++) begin
                    if (wr_lane[p][i]) rd_d[p][i] = wdata[p][i];
                end
            end
        end
    end

    // Port A is written last so it wins any lane both ports touch.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (wr_lane[1][i]) mem[addr[1]][i] <= wdata[1][i];
            if (wr_lane[0][i]) mem[addr[0]][i] <= wdata[0][i];
        end
    end

    always_comb begin
        vld_pipe_d = '0;
        dat_pipe_d = dat_pipe_q;
        for (int p = 0; p < 2; p++) begin
            vld_pipe_d[p][0] = usr_acc[p];
            if (usr_acc[p]) dat_pipe_d[p][0] = rd_d[p];
            for (int s = 1; s < STAGES; s++) begin
                vld_pipe_d[p][s] = vld_pipe_q[p][s-1];
                if (vld_pipe_q[p][s-1]) dat_pipe_d[p][s] = dat_pipe_q[p][s-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe_q  <= '0;
            dat_pipe_q  <= '0;
            collision_q <= 1'b0;
        end else begin
            vld_pipe_q  <= vld_pipe_d;
            dat_pipe_q  <= dat_pipe_d;
            collision_q <= collision_d;
        end
    end

    assign q_a       = dat_pipe_q[0][STAGES-1];
    assign q_b       = dat_pipe_q[1][STAGES-1];
    assign valid_a   = vld_pipe_q[0][STAGES-1];
    assign valid_b   = vld_pipe_q[1][STAGES-1];
    assign collision = collision_q;

endmodule

// File: doc/dcache_dual_port_ram.md
DCACHE_DUAL_PORT_RAM -- requirements
Module: dcache_dual_port_ram

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, word width in bits, a multiple of 8.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 5, giving a depth of 2**ADDR_WIDTH words.
REQ-003 The block SHALL have parameter OUT_REG, default 0, where 1 adds an output register stage to both ports.
REQ-004 The block SHALL have parameter RDW_MODE, default RDW_NEW, selecting same-port read-during-write data as RDW_NEW or RDW_OLD.
REQ-005 The block SHALL have parameter CLEAR_ON_RESET, default 1, where 1 zero-fills the array after reset.
REQ-006 clk  input  1  the single clock; all logic SHALL be rising-edge.
REQ-007 rst  input  1  reset, asynchronous and active-high.
REQ-008 en_a, en_b  input  1  port access request.
REQ-009 we_a, we_b  input  1  write qualifier, valid only when en is high.
REQ-010 be_a, be_b  input  DATA_WIDTH/8  byte-lane write enables.
REQ-011 addr_a, addr_b  input  ADDR_WIDTH  word address.
REQ-012 data_a, data_b  input  DATA_WIDTH  write data.
REQ-013 q_a, q_b  output  DATA_WIDTH  read data.
REQ-014 valid_a, valid_b  output  1  q holds the result of an accepted access.
REQ-015 busy  output  1  clear engine is running; all port requests are ignored.
REQ-016 collision  output  1  one-cycle pulse on a same-address dual-write conflict.

Function
REQ-017 Access latency SHALL be 1 cycle for OUT_REG=0 and 2 cycles for OUT_REG=1, measured from the en edge to valid/q; the ports SHALL be fully pipelined, accepting one access per port per cycle.
REQ-018 On a write, only the lanes with be bit set SHALL be updated; be=0 with we=1 SHALL behave as a read.
REQ-019 For a same-port write, q SHALL return the merged new word when RDW_MODE=RDW_NEW, or the pre-write word when RDW_MODE=RDW_OLD.
REQ-020 When one port reads an address that the other port writes in the same cycle, the reading port SHALL return the pre-write word.
REQ-021 When both ports write the same address in the same cycle, port A SHALL win on lanes where both be bits are set, port B's other lanes SHALL still be written, and collision SHALL pulse high if any lane overlapped.
REQ-022 The clear engine SHALL use states CLEAR and READY: CLEAR writes zero to address 0 through 2**ADDR_WIDTH-1, one address per cycle, then moves to READY.
REQ-023 busy SHALL be high while in CLEAR, for exactly 2**ADDR_WIDTH cycles starting at the first clk edge after rst deasserts.
REQ-024 Accesses with en high while busy is high SHALL be dropped and SHALL produce no valid.
REQ-025 With CLEAR_ON_RESET=0, the engine SHALL enter READY directly, busy SHALL stay 0, and array contents SHALL be undefined until written.
REQ-026 valid SHALL be low in any cycle that does not correspond to an accepted access; q SHALL hold its last value while valid is low.

Reset
REQ-027 Asserting rst SHALL immediately force q_a, q_b to 0, valid_a, valid_b and collision to 0, and the engine into CLEAR (busy=1) when CLEAR_ON_RESET=1, or READY otherwise.
REQ-028 Asserting rst mid-clear or mid-pipeline SHALL discard in-flight accesses and restart the clear from address 0.
REQ-029 The storage array itself SHALL not be reset; the clear engine alone initialises it.

Structure
REQ-030 The RDW_NEW and RDW_OLD constants and the clear state encoding SHALL live in the shared package dcache_ram_pkg.
REQ-031 The clear FSM and its address counter SHALL be the sub-module ram_clear_ctrl, which muxes onto port A's write path while busy.

Verification
REQ-032 rst pulse with defaults -> busy high for 32 cycles, then a read of address 31 returns 0x00000000 with valid_a one cycle later.
REQ-033 A writes 0xAABBCCDD to address 3 with be=1111, then A writes 0x11223344 with be=0101 -> a read returns 0xAA22CC44.
REQ-034 Same cycle, A writes 0x11111111 and B writes 0x22222222 to address 7, be_a=0011, be_b=1111 -> collision pulses once and a read returns 0x22221111.
REQ-035 RDW_OLD, address 4 holds 0x5, A writes 0x9 -> q_a=0x5; RDW_NEW -> q_a=0x9; B reading address 4 in the same cycle -> q_b=0x5.
REQ-036 OUT_REG=1, back-to-back reads of addresses 0..3 -> valid_a high for 4 consecutive cycles starting 2 cycles after the first en_a.
REQ-037 rst asserted at clear address 10 -> q and valid drop at once, and busy remains high for a full 32 cycles after release.
